// File: rtl/scan_keycode.sv
`default_nettype none
// ============================================================================
// Module   : scan_keycode
// Purpose  : Front-end for the calculator operation block. Turns PS/2 Set-2
//            scan-code bytes into 0..14 key codes with a one-cycle select
//            strobe, plus a separate clear request for Esc. Tracks the E0
//            (extended) and F0 (break) prefixes and discards key releases.
//            A prefix that waits too long for its next byte is abandoned and
//            flagged on prefix_err.
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            scan_data  - scan-code byte, qualified by scan_valid
//            scan_valid - one-cycle strobe, scan_data valid
//            key_code   - decoded key code, zero-extended, held between strobes
//            key_valid  - one-cycle strobe, new key_code (operation block sel)
//            clr_req    - one-cycle strobe on Esc make
//            prefix_err - sticky prefix-timeout flag, cleared only by rst
// Options  : REPEAT_FILTER_EN - when defined, a held-key register suppresses
//            typematic auto-repeat of the most recently emitted make.
// Revision : 1.0 - initial release
// ============================================================================
module scan_keycode #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CODE_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        scan_data,
  input  logic              scan_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              clr_req,
  output logic              prefix_err
);

  localparam int              CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_clr_req;
  logic              r_prefix_err;

  // Lookup of the normal (non-extended) make table
  logic              w_lut_valid;
  logic              w_lut_esc;
  logic [3:0]        w_lut_code;

  // FSM decisions for the current cycle
  logic              w_make;      // a key make completes this cycle
  logic              w_esc;       // an Esc make completes this cycle
  logic [3:0]        w_code;      // key code of w_make
  logic              w_mk_ext;    // the completing make was E0-prefixed
  logic              w_brk;       // a break code completes this cycle
  logic              w_brk_ext;   // the completing break was E0-prefixed
  logic              w_set_err;   // prefix timeout this cycle
  logic              w_drop;      // suppress the strobe (auto-repeat)

  always_comb begin
    w_lut_valid = 1'b1;
    w_lut_esc   = 1'b0;
    w_lut_code  = 4'd0;
    case (scan_data)
      8'h45, 8'h70: w_lut_code = 4'd0;
      8'h16, 8'h69: w_lut_code = 4'd1;
      8'h1E, 8'h72: w_lut_code = 4'd2;
      8'h26, 8'h7A: w_lut_code = 4'd3;
      8'h25, 8'h6B: w_lut_code = 4'd4;
      8'h2E, 8'h73: w_lut_code = 4'd5;
      8'h36, 8'h74: w_lut_code = 4'd6;
      8'h3D, 8'h6C: w_lut_code = 4'd7;
      8'h3E, 8'h75: w_lut_code = 4'd8;
      8'h46, 8'h7D: w_lut_code = 4'd9;
      8'h79, 8'h55: w_lut_code = 4'd10;
      8'h7B, 8'h4E: w_lut_code = 4'd11;
      8'h7C:        w_lut_code = 4'd12;
      8'h66:        w_lut_code = 4'd13;
      8'h5A:        w_lut_code = 4'd14;
      8'h76: begin
        w_lut_valid = 1'b0;
        w_lut_esc   = 1'b1;
      end
      default:      w_lut_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_make      = 1'b0;
    w_esc       = 1'b0;
    w_code      = 4'd0;
    w_mk_ext    = 1'b0;
    w_brk       = 1'b0;
    w_brk_ext   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (scan_valid) begin
          case (scan_data)
            8'hE0: w_state_nxt = S_EXT;
            8'hF0: w_state_nxt = S_BRK;
            // Keyboard self-test / ack / echo / error bytes carry no key
            8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: ;
            default: begin
              w_make = w_lut_valid;
              w_esc  = w_lut_esc;
              w_code = w_lut_code;
            end
          endcase
        end
      end
      S_EXT: begin
        if (scan_valid) begin
          w_cnt_nxt = '0;
          if (scan_data == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (scan_data == 8'h5A) begin
              w_make   = 1'b1;
              w_code   = 4'd14;
              w_mk_ext = 1'b1;
            end
          end
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_set_err   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BRK, S_EXT_BRK: begin
        if (scan_valid) begin
          // A release never produces a strobe; it only ends the prefix
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_brk       = 1'b1;
          w_brk_ext   = (r_state == S_EXT_BRK);
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_set_err   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef REPEAT_FILTER_EN
  // Held key: {ext bit, byte} of the last emitted make, valid while r_held
  logic [8:0] r_held_key;
  logic       r_held;

  assign w_drop = r_held && (r_held_key == {w_mk_ext, scan_data});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_key <= '0;
      r_held     <= 1'b0;
    end else if ((w_make || w_esc) && !w_drop) begin
      r_held_key <= {w_mk_ext, scan_data};
      r_held     <= 1'b1;
    end else if (w_brk && r_held && (r_held_key == {w_brk_ext, scan_data})) begin
      r_held     <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_drop   = 1'b0;
  assign w_unused = ^{w_mk_ext, w_brk, w_brk_ext};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_code   <= '0;
      r_key_valid  <= 1'b0;
      r_clr_req    <= 1'b0;
      r_prefix_err <= 1'b0;
    end else begin
      r_key_valid <= w_make && !w_drop;
      r_clr_req   <= w_esc && !w_drop;
      if (w_make && !w_drop) begin
        r_key_code <= CODE_W'(w_code);
      end
      if (w_set_err) begin
        r_prefix_err <= 1'b1;
      end
    end
  end

  assign key_code   = r_key_code;
  assign key_valid  = r_key_valid;
  assign clr_req    = r_clr_req;
  assign prefix_err = r_prefix_err;

endmodule
`default_nettype wire

// File: tb/tb_scan_keycode.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_keycode
// Purpose  : Directed self-checking bench for scan_keycode with a short
//            prefix timeout (16 cycles). Bytes are driven on the falling edge
//            and outputs are sampled 1 time unit after the rising edge that
//            consumed the byte, so each check sees the registered response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_keycode;

  localparam int TIMEOUT_CYC = 16;
  localparam int CODE_W      = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        scan_data = 8'h00;
  logic              scan_valid = 1'b0;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              clr_req;
  logic              prefix_err;

  int checks = 0;
  int errors = 0;
  int strobes;

  scan_keycode #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CODE_W     (CODE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_data (scan_data),
    .scan_valid(scan_valid),
    .key_code  (key_code),
    .key_valid (key_valid),
    .clr_req   (clr_req),
    .prefix_err(prefix_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns just after the edge that
  // consumed it, so the registered response is visible.
  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    scan_data  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic kv, input logic [CODE_W-1:0] kc,
                         input logic cr);
    chk({tag, ".kv"},   32'(key_valid), 32'(kv));
    chk({tag, ".code"}, 32'(key_code),  32'(kc));
    chk({tag, ".clr"},  32'(clr_req),   32'(cr));
  endtask

  initial begin
    // Reset state
    idle(2);
    chk_out("reset", 1'b0, 11'd0, 1'b0);
    chk("reset.err", 32'(prefix_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Make then break of key '1'
    drive(8'h16); chk_out("mk16",    1'b1, 11'd1, 1'b0);
    drive(8'hF0); chk_out("brkF0",   1'b0, 11'd1, 1'b0);
    drive(8'h16); chk_out("brk16",   1'b0, 11'd1, 1'b0);

    // Back-to-back bytes on consecutive cycles
    drive(8'h1E); chk_out("b2b_1E",  1'b1, 11'd2,  1'b0);
    drive(8'h7C); chk_out("b2b_7C",  1'b1, 11'd12, 1'b0);
    drive(8'h26); chk_out("b2b_26",  1'b1, 11'd3,  1'b0);
    drive(8'h5A); chk_out("b2b_5A",  1'b1, 11'd14, 1'b0);
    idle(1);      chk_out("b2b_end", 1'b0, 11'd14, 1'b0);

    // Extended prefix handling
    drive(8'h45); chk_out("mk45",    1'b1, 11'd0,  1'b0);
    drive(8'hE0); chk_out("extE0",   1'b0, 11'd0,  1'b0);
    drive(8'h5A); chk_out("kpEnter", 1'b1, 11'd14, 1'b0);
    drive(8'h45); chk_out("mk45b",   1'b1, 11'd0,  1'b0);
    drive(8'hE0); chk_out("ebE0",    1'b0, 11'd0,  1'b0);
    drive(8'hF0); chk_out("ebF0",    1'b0, 11'd0,  1'b0);
    drive(8'h5A); chk_out("eb5A",    1'b0, 11'd0,  1'b0);
    drive(8'hE0); chk_out("e70_E0",  1'b0, 11'd0,  1'b0);
    drive(8'h70); chk_out("e70_70",  1'b0, 11'd0,  1'b0);
    drive(8'h69); chk_out("mk69",    1'b1, 11'd1,  1'b0);

    // Esc, ignored bytes, unknown byte, remaining table entries
    drive(8'h76); chk_out("esc",     1'b0, 11'd1,  1'b1);
    idle(1);      chk_out("esc_end", 1'b0, 11'd1,  1'b0);
    drive(8'hAA); chk_out("ignAA",   1'b0, 11'd1,  1'b0);
    drive(8'hFA); chk_out("ignFA",   1'b0, 11'd1,  1'b0);
    drive(8'hFF); chk_out("ignFF",   1'b0, 11'd1,  1'b0);
    drive(8'h1C); chk_out("unk1C",   1'b0, 11'd1,  1'b0);
    drive(8'h79); chk_out("plus",    1'b1, 11'd10, 1'b0);
    drive(8'h4E); chk_out("minus",   1'b1, 11'd11, 1'b0);
    drive(8'h66); chk_out("bksp",    1'b1, 11'd13, 1'b0);
    drive(8'h7D); chk_out("kp9",     1'b1, 11'd9,  1'b0);

    // Prefix timeout: err rises on the 16th idle cycle after E0
    drive(8'hE0);
    idle(15);     chk("to.err15", 32'(prefix_err), 32'd0);
    idle(1);      chk("to.err16", 32'(prefix_err), 32'd1);
    chk_out("to.quiet", 1'b0, 11'd9, 1'b0);
    idle(4);
    drive(8'h45); chk_out("to.mk45", 1'b1, 11'd0, 1'b0);
    chk("to.sticky", 32'(prefix_err), 32'd1);

    // Reset mid-prefix discards E0; 70 then decodes as a normal make
    drive(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.err", 32'(prefix_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    drive(8'h70); chk_out("rst.mk70", 1'b1, 11'd0, 1'b0);
    drive(8'h5A); chk_out("rst.mk5A", 1'b1, 11'd14, 1'b0);
    chk("rst.err2", 32'(prefix_err), 32'd0);

    // rst and scan_valid in the same cycle: byte discarded
    @(negedge clk);
    rst = 1'b1; scan_data = 8'h16; scan_valid = 1'b1;
    @(posedge clk); #1;
    chk_out("rstv", 1'b0, 11'd0, 1'b0);
    @(negedge clk); rst = 1'b0; scan_valid = 1'b0;
    idle(1);      chk_out("rstv2", 1'b0, 11'd0, 1'b0);

    // Typematic repeat: 3D 3D 3D F0 3D 3D
    strobes = 0;
    drive(8'h3D); strobes += int'(key_valid); chk("rep.code", 32'(key_code), 32'd7);
    drive(8'h3D); strobes += int'(key_valid);
    drive(8'h3D); strobes += int'(key_valid);
    drive(8'hF0); strobes += int'(key_valid);
    drive(8'h3D); strobes += int'(key_valid);
    drive(8'h3D); strobes += int'(key_valid);
    chk("rep.code2", 32'(key_code), 32'd7);
`ifdef REPEAT_FILTER_EN
    chk("rep.count", 32'(strobes), 32'd2);
`else
    chk("rep.count", 32'(strobes), 32'd4);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
